// File: rtl/memshare_rqst_sched_if.sv
// Read-port bundle between the memShare scheduler (master) and the
// message-passing buffer read port (slave).
interface memshare_rqst_sched_if #(
    parameter int GRP_NUM = 4,
    parameter int ADDR_W  = 6
);
    // Handshake: a beat transfers on any rising clock edge where rd_valid_o
    // and rd_ready_i are both high. While rd_valid_o is high and rd_ready_i
    // is low, rd_valid_o, rd_addr_o and grant_o hold stable. burst_last_o
    // is only meaningful in a transfer cycle.
    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic [ADDR_W-1:0]    rd_addr_o;
    logic [GRP_NUM-1:0]   grant_o;
    logic                 burst_last_o;

    modport master (
        output rd_valid_o,
        output rd_addr_o,
        output grant_o,
        output burst_last_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o,
        input  rd_addr_o,
        input  grant_o,
        input  burst_last_o,
        output rd_ready_i
    );
endinterface

// File: rtl/memshare_rqst_sched.sv
// Once-per-SCU round-robin scheduler for the message-passing buffer read
// port: one burst per requesting share group, with DRC1 address rebasing.
module memshare_rqst_sched #(
    parameter int GRP_NUM   = 4,
    parameter int BURST_LEN = 3,
    parameter int ADDR_W    = 6,
    parameter int ADDR_BASE = 0
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 scu_begin_i,
    input  logic [GRP_NUM-1:0]   rqst_i,
    input  logic [2:0]           is_drc_i,
    input  logic [ADDR_W-1:0]    rebase_addr_i,
    memshare_rqst_sched_if.master rd_if,
    output logic                 scu_done_o,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    localparam int GW = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_ISSUE  = 3'd2,
        S_REBASE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GRP_NUM-1:0]   served_q, served_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [GRP_NUM-1:0]   grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 xfer;
    logic                 drc1;
    logic                 last_beat;
    logic [GRP_NUM-1:0]   eligible;
    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [GW-1:0]        grant_idx;
    logic [GW-1:0]        rr_next;

    assign xfer      = valid_q & rd_if.rd_ready_i;
    assign drc1      = (is_drc_i == 3'b001);
    assign last_beat = (beat_cnt_q == BW'(BURST_LEN - 1));
    assign eligible  = rqst_i & ~served_q;

    // Circular first-set search starting at rr_ptr_q.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < GRP_NUM; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= GRP_NUM) idx = idx - GRP_NUM;
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < GRP_NUM; i++) begin
            if (grant_q[i]) grant_idx = GW'(i);
        end
    end

    assign rr_next = (grant_idx == GW'(GRP_NUM - 1)) ? '0 : grant_idx + GW'(1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rr_ptr_d   = rr_ptr_q;
        served_d   = served_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        case (state_q)
            S_IDLE: begin
                if (scu_begin_i) begin
                    state_d  = S_ARB;
                    addr_d   = BASE;
                    rr_ptr_d = '0;
                    served_d = '0;
                end
            end
            S_ARB: begin
                if (pick_found) begin
                    grant_d    = GRP_NUM'(1) << pick_idx;
                    beat_cnt_d = '0;
                    state_d    = S_ISSUE;
                end else begin
                    grant_d = '0;
                    state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    addr_d     = drc1 ? rebase_addr_i : addr_q + ADDR_W'(1);
                    if (last_beat) begin
                        served_d = served_q | grant_q;
                        rr_ptr_d = rr_next;
                    end
                    // A DRC1 rebase always inserts a bubble, even after the last beat.
                    if (drc1) begin
                        state_d = S_REBASE;
                    end else if (last_beat) begin
                        grant_d = '0;
                        state_d = S_ARB;
                    end
                end
            end
            S_REBASE: begin
                if (beat_cnt_q == BW'(BURST_LEN)) begin
                    grant_d = '0;
                    state_d = S_ARB;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    assign valid_d = (state_d == S_ISSUE);
    assign done_d  = (state_d == S_DONE);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge sys_clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE;
            rr_ptr_q   <= '0;
            served_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rr_ptr_q   <= rr_ptr_d;
            served_q   <= served_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_if.rd_valid_o   = valid_q;
    assign rd_if.rd_addr_o    = addr_q;
    assign rd_if.grant_o      = grant_q;
    assign rd_if.burst_last_o = xfer & last_beat;
    assign scu_done_o         = done_q;
    assign busy_o             = busy_q;
    assign dbg_state_o        = state_q;

endmodule

// File: doc/memshare_rqst_sched.md
Name: memshare_rqst_sched

Overview:
Scheduler for the message-passing buffer read port during the SCU.memShare() period. Once per SCU it grants each requesting share group one read burst, in round-robin order. It generates the sequential read addresses and rebases the address stream when an exclusive DRC1 condition is reported. It sits between the memShare request generators and the message-passing buffer read port.

Parameters:
GRP_NUM, 4, number of share groups (requesters); at least 2
BURST_LEN, 3, read beats per grant; at least 1
ADDR_W, 6, read address width (MSGPASS_BUFF_ADDR_WIDTH)
ADDR_BASE, 0, start address loaded at each SCU begin (MSGPASS_ADDR_BASE)

Ports:
sys_clk  in  1  clock, rising edge
rstn  in  1  asynchronous, active-high reset (1 = reset asserted)
scu_begin_i  in  1  single-cycle pulse marking the start of SCU.memShare()
rqst_i  in  GRP_NUM  per-group request level
is_drc_i  in  3  DRC flags; bit0=DRC1, bit1=DRC2, bit2=DRC3
rebase_addr_i  in  ADDR_W  rebase address used on exclusive DRC1
rd_valid_o  out  1  read request valid
rd_ready_i  in  1  buffer accepts the request
rd_addr_o  out  ADDR_W  read address
grant_o  out  GRP_NUM  one-hot current grant, 0 when no grant
burst_last_o  out  1  high on the final accepted beat of a burst
scu_done_o  out  1  single-cycle pulse when the SCU schedule completes
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-burst): state=IDLE, addr_q=ADDR_BASE, rr_ptr=0, served mask=0, beat_cnt=0. All outputs are 0 and rd_addr_o=ADDR_BASE.
- States: IDLE, ARB, ISSUE, REBASE, DONE.
- IDLE: when scu_begin_i=1, go to ARB next cycle and clear addr_q to ADDR_BASE, rr_ptr to 0 and the served mask. scu_begin_i is ignored in every other state.
- ARB (1 cycle): eligible = rqst_i & ~served.
  - If eligible != 0: pick the first set bit searching circularly from rr_ptr. Register it into grant_o, set beat_cnt=0, go to ISSUE.
  - Otherwise go to DONE with grant_o=0.
- ISSUE: rd_valid_o=1 and rd_addr_o=addr_q.
  - A transfer occurs when rd_valid_o && rd_ready_i.
  - While rd_ready_i=0, valid, address and grant all hold stable.
  - Deasserting rqst_i mid-burst does not abort the burst.
- On a transfer:
  - beat_cnt increments.
  - addr_q becomes addr_q+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - Exclusive DRC1 means is_drc_i==3'b001, and it is sampled only on transfer cycles. In that case addr_q takes rebase_addr_i instead and the next state is REBASE, even when the beat is the last one.
  - Any other is_drc_i value causes a normal increment.
- Last beat (beat_cnt==BURST_LEN-1 on a transfer):
  - burst_last_o=1 in that cycle.
  - The granted group is set in the served mask and rr_ptr = granted index+1 mod GRP_NUM.
  - Next state is ARB, or REBASE when DRC1 fired.
  - grant_o clears on leaving ISSUE.
- REBASE (1 bubble cycle): rd_valid_o=0 and grant_o is held.
  - If the burst is incomplete, return to ISSUE.
  - Otherwise clear grant_o and go to ARB.
- DONE: scu_done_o=1 for exactly 1 cycle, then IDLE.
- Each group is served at most once per SCU. A request that rises after its group is served waits for the next scu_begin_i.
- rd_addr_o is registered (addr_q). Latency from scu_begin_i to the first rd_valid_o is 2 cycles.

Test Plan:
- Reset, then scu_begin_i with rqst_i=4'b1111 and rd_ready_i=1:
  - bursts go to g0, g1, g2, g3 in that order.
  - Addresses are 0..11, with 3 beats per grant and 1 ARB cycle between bursts.
  - burst_last_o is high on addresses 2, 5, 8 and 11.
  - scu_done_o pulses once, and busy_o falls the following cycle.
- rqst_i=4'b0100 only: first rd_valid_o appears 2 cycles after scu_begin_i with grant_o=4'b0100 and addresses 0, 1, 2, followed by ARB, DONE and IDLE.
- Backpressure with rd_ready_i=0 for 4 cycles on beat 1 of g0: rd_addr_o holds 1 and grant_o holds 4'b0001; the burst finishes with 0, 1, 2.
- is_drc_i=3'b001 with rebase_addr_i=6'd40 on beat 0 of g1 (address 3):
  - 1 bubble cycle follows.
  - Beats continue at 40, 41 with grant_o held.
  - g2 then starts at 42.
  - Repeating with is_drc_i=3'b011 gives a normal increment and no bubble.
- Wrap-around: rebase_addr_i=63 via DRC1 in mid-burst → following addresses are 63, 0.
- Reset asserted mid-burst (addr 7): outputs clear immediately. After release, scu_begin_i restarts from address 0 with g0.
